// File: rtl/jpeg_unstuff_bitbuf_if.sv
// rtl/jpeg_unstuff_bitbuf_if.sv - stuffed scan word input and peek/consume bit window bundle
interface jpeg_unstuff_bitbuf_if #(
  parameter int IN_W  = 32,
  parameter int BUF_W = 64,
  parameter int WIN_W = 32
);
  logic                     flush_i;
  logic [IN_W-1:0]          data_i;
  logic                     data_valid_i;
  logic                     data_ready_o;
  logic [WIN_W-1:0]         win_o;
  logic [$clog2(BUF_W):0]   avail_o;
  logic                     consume_i;
  logic [$clog2(WIN_W):0]   consume_len_i;
  logic                     err_o;
  logic                     marker_o;
  logic [7:0]               marker_code_o;

  modport slave (
    input  flush_i, data_i, data_valid_i, consume_i, consume_len_i,
    output data_ready_o, win_o, avail_o, err_o, marker_o, marker_code_o
  );

  modport master (
    output flush_i, data_i, data_valid_i, consume_i, consume_len_i,
    input  data_ready_o, win_o, avail_o, err_o, marker_o, marker_code_o
  );
endinterface

// File: rtl/jpeg_unstuff_bitbuf.sv
// rtl/jpeg_unstuff_bitbuf.sv - JPEG 0xFF00 unstuffer feeding an MSB-first peek/consume bit buffer
// Optional marker detection/halt is enabled by defining JPEG_UNSTUFF_MARKER_EN.
module jpeg_unstuff_bitbuf #(
  parameter int IN_W  = 32,
  parameter int BUF_W = 64,
  parameter int WIN_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  jpeg_unstuff_bitbuf_if.slave bus
);
  localparam int FILL_W = $clog2(BUF_W) + 1;
  localparam int NBYTES = IN_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {EMPTY, DRAIN, HALT} state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     word_q;
  logic [IDX_W-1:0]    idx_q;
  logic                pend_q, pend_d;
  logic [BUF_W-1:0]    bits_q, bits_cons, bits_next;
  logic [FILL_W-1:0]   fill_q, fill_cons, fill_next;
  logic                err_q;
  logic                load_en, advance;
  logic [7:0]          load_byte, cur;
  logic                room, last, accept, cons_ok, cons_bad;
`ifdef JPEG_UNSTUFF_MARKER_EN
  logic                marker_hit;
`endif

  // The unconsumed byte of the held word is always at its top; advancing shifts it out.
  assign cur      = word_q[IN_W-1 -: 8];
  assign room     = fill_q <= FILL_W'(BUF_W - 8);
  assign last     = idx_q == IDX_W'(NBYTES - 1);
  assign accept   = (state_q == EMPTY) && bus.data_valid_i;
  assign cons_ok  = bus.consume_i && (FILL_W'(bus.consume_len_i) <= fill_q);
  assign cons_bad = bus.consume_i && !cons_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            state_q <= EMPTY;
    else if (bus.flush_i) state_q <= EMPTY;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    load_en   = 1'b0;
    load_byte = cur;
    advance   = 1'b0;
`ifdef JPEG_UNSTUFF_MARKER_EN
    marker_hit = 1'b0;
`endif
    case (state_q)
      EMPTY: if (bus.data_valid_i) state_d = DRAIN;
      DRAIN: if (room) begin
        if (!pend_q) begin
          if (cur == 8'hFF) pend_d = 1'b1;
          else              load_en = 1'b1;
          advance = 1'b1;
        end else if (cur == 8'h00) begin
          load_en   = 1'b1;
          load_byte = 8'hFF;
          pend_d    = 1'b0;
          advance   = 1'b1;
        end else begin
`ifdef JPEG_UNSTUFF_MARKER_EN
          if (cur == 8'hFF) begin
            advance = 1'b1;
          end else begin
            marker_hit = 1'b1;
            state_d    = HALT;
          end
`else
          // Lone FF: keep it as data and re-examine this byte next cycle.
          load_en   = 1'b1;
          load_byte = 8'hFF;
          pend_d    = 1'b0;
`endif
        end
        if (advance && last) state_d = EMPTY;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    bits_cons = cons_ok ? (bits_q << bus.consume_len_i) : bits_q;
    fill_cons = cons_ok ? (fill_q - FILL_W'(bus.consume_len_i)) : fill_q;
    bits_next = bits_cons;
    fill_next = fill_cons;
    if (load_en) begin
      bits_next = bits_cons | ({load_byte, {(BUF_W-8){1'b0}}} >> fill_cons);
      fill_next = fill_cons + FILL_W'(8);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bus.flush_i) begin
      word_q <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      bits_q <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        word_q <= bus.data_i;
        idx_q  <= '0;
      end else if (advance) begin
        word_q <= word_q << 8;
        idx_q  <= idx_q + IDX_W'(1);
      end
      pend_q <= pend_d;
      bits_q <= bits_next;
      fill_q <= fill_next;
      if (cons_bad) err_q <= 1'b1;
    end
  end

  assign bus.data_ready_o = (state_q == EMPTY);
  assign bus.win_o        = bits_q[BUF_W-1 -: WIN_W];
  assign bus.avail_o      = fill_q;
  assign bus.err_o        = err_q;

`ifdef JPEG_UNSTUFF_MARKER_EN
  logic       marker_q;
  logic [7:0] code_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bus.flush_i) begin
      marker_q <= 1'b0;
      code_q   <= 8'h00;
    end else if (marker_hit) begin
      marker_q <= 1'b1;
      code_q   <= cur;
    end
  end

  assign bus.marker_o      = marker_q;
  assign bus.marker_code_o = code_q;
`else
  assign bus.marker_o      = 1'b0;
  assign bus.marker_code_o = 8'h00;
`endif
endmodule
